// File: rtl/sram_pkg.sv
// Shared types for the SRAM access sequencer: FSM states and phase counter width.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } sram_state_e;

  localparam int CNT_W = 3;

endpackage

// File: rtl/sram_access_sequencer.sv
// SRAM access sequencer: precharge, wordline/column access, then response pulse.
// Optional completed-access counter enabled with macro SRAM_SEQ_ACC_COUNT_EN.
module sram_access_sequencer
  import sram_pkg::*;
#(
  parameter int ROW_BITS   = 4,
  parameter int COL_BITS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PRE_CYCLES = 1,
  parameter int ACC_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         rsp_valid,
  output logic                         rsp_we,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic [ROW_BITS-1:0]          row_addr,
  output logic                         row_en,
  output logic [COL_BITS-1:0]          col_addr,
  output logic                         col_en,
  output logic                         precharge,
  output logic                         sense_en,
  output logic                         write_en,
  output logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH-1:0]        bl_data,
  output logic [15:0]                  acc_count
);

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_LD = CNT_W'(ACC_CYCLES - 1);

  sram_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic we_q;
  logic accept;
  logic last_acc;

  assign accept   = (state == IDLE) && req_valid && req_ready;
  assign last_acc = (state == ACC) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PRE;
          cnt_nxt   = PRE_LD;
        end
      end
      PRE: begin
        if (cnt == '0) begin
          state_nxt = ACC;
          cnt_nxt   = ACC_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ACC: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      req_ready <= 1'b0;
      precharge <= 1'b0;
      row_en    <= 1'b0;
      col_en    <= 1'b0;
      sense_en  <= 1'b0;
      write_en  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      row_addr  <= '0;
      col_addr  <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      precharge <= (state_nxt == PRE);
      row_en    <= (state_nxt == ACC);
      col_en    <= (state_nxt == ACC);
      write_en  <= (state_nxt == ACC) && we_q;
      sense_en  <= (state_nxt == ACC) && !we_q
                   && (cnt_nxt == '0);
      rsp_valid <= (state_nxt == DONE);
      rsp_we    <= (state_nxt == DONE) && we_q;
      if (accept) begin
        we_q     <= req_we;
        row_addr <= req_addr[COL_BITS +: ROW_BITS];
        col_addr <= req_addr[COL_BITS-1:0];
        wr_data  <= req_wdata;
      end
      if (last_acc && !we_q) begin
        rsp_rdata <= bl_data;
      end
    end
  end

`ifdef SRAM_SEQ_ACC_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_count <= '0;
    end else if (rsp_valid && (acc_count != 16'hFFFF)) begin
      acc_count <= acc_count + 16'd1;
    end
  end
`else
  assign acc_count = '0;
`endif

endmodule
